cache_controller: RTL
=====================

# cache_controller

Control stage between the MEM pipeline stage and the 2-way, 64-set data cache with its SRAM controller. It translates byte addresses to 17-bit cache word addresses and serves read hits from the cache in zero wait cycles. On a read miss it fetches a 64-bit line from SRAM and fills the cache. Writes go write-through / no-write-allocate, invalidating any cached copy. It drives `ready` low to freeze the pipeline while an SRAM transaction is outstanding and keeps saturating hit/miss counters.

## Interface
Parameters:
- `BASE_ADDR`, 1024: byte address of data-memory word 0.
- `CNT_W`, 16: width of the hit and miss counters.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_addr` in 32: byte address from MEM stage.
- `mem_wdata` in 32: store data.
- `mem_r_en` in 1: load request.
- `mem_w_en` in 1: store request.
- `mem_rdata` out 32: load data, valid when `ready`=1 and the load completes.
- `ready` out 1: 0 = freeze pipeline.
- `cache_address` out 17: {tag[9:0], index[5:0], offset}.
- `cache_write_data` out 64: line fill data; {word1, word0}.
- `cache_read_en` out 1: cache lookup/fill enable.
- `cache_write_en` out 1: cache fill enable.
- `cache_invalid` out 1: invalidate the line on hit.
- `cache_hit` in 1: combinational hit from the cache.
- `cache_read_data` in 32: combinational hit data from the cache.
- `sram_addr` out 32: byte address to the SRAM controller.
- `sram_wdata` out 32: store data.
- `sram_r_en` out 1: line read request.
- `sram_w_en` out 1: word write request.
- `sram_rdata` in 64: line data; bits 31:0 are the even word.
- `sram_ready` in 1: single-cycle pulse marking transaction completion.
- `hit_count` out CNT_W: saturating load-hit counter.
- `miss_count` out CNT_W: saturating load-miss counter.

## Operation
- Address map: `off = mem_addr - BASE_ADDR` (32-bit, wrap allowed); `cache_address = off[18:2]`; `sram_addr = mem_addr`.
- The address and store data are latched into `req_addr`/`req_wdata` on request acceptance in IDLE. In MISS/WRITE, all cache and SRAM outputs use the latched values.
- If `mem_r_en` and `mem_w_en` are both 1, the request is a store.
- FSM states: IDLE, MISS, WRITE.
- IDLE, no request:
  - `ready`=1; all strobes 0.
- IDLE, load:
  - `cache_read_en`=1.
  - Hit: `mem_rdata=cache_read_data`, `ready`=1, `hit_count`++ ; stay in IDLE.
  - Miss: `ready`=0, `sram_r_en`=1, `miss_count`++; go to MISS.
- MISS:
  - `sram_r_en`=1, `ready`=0, `cache_read_en`=1.
  - On `sram_ready`: `cache_write_en`=1 and `cache_write_data=sram_rdata` (the cache fills its LRU way at that edge).
  - On `sram_ready`: `mem_rdata` = `sram_rdata[63:32]` if `req_addr` offset bit=1, else `sram_rdata[31:0]`.
  - On `sram_ready`: `ready`=1; go to IDLE.
- IDLE, store:
  - `cache_invalid`=1 for exactly this cycle.
  - `sram_w_en`=1, `ready`=0; go to WRITE.
- WRITE:
  - `sram_w_en`=1; `cache_invalid`=0.
  - On `sram_ready`: `ready`=1; go to IDLE.
  - No cache fill and no counter change.
- Counters saturate at all-ones and never wrap.
- `mem_rdata` is 0 whenever no load completes in that cycle.

## Timing
- Load hit: 0 wait cycles; data is combinational in the request cycle.
- Load miss: `ready` is low from the request cycle through the cycle before `sram_ready`. Data is presented in the `sram_ready` cycle. Latency = SRAM latency + 1 cycle.
- Store: `ready` is low from the request cycle until the `sram_ready` cycle.
- `sram_ready` in IDLE is ignored.
- The requester holds `mem_*` stable while `ready`=0. Changes are ignored, since latched values are used.
- Reset while `rst`=0:
  - State goes to IDLE; latches and counters clear to 0.
  - `ready`=0, `mem_rdata`=0, and all cache/SRAM strobes are 0.
- Reset mid-MISS/WRITE: the transaction is abandoned with no cache fill. The SRAM controller is reset by the same `rst`.
- After `rst` deasserts, the first edge may accept a request.

## Structure
- Shared package `cache_pkg` holds:
  - State enum {IDLE, MISS, WRITE}.
  - `TAG_W`=10, `IDX_W`=6, `OFF_W`=1, `CACHE_ADDR_W`=17, `LINE_W`=64, `WORD_W`=32.
- One sub-module: `sat_counter` (width parameter, enable, async active-low clear), instantiated twice.

## Test plan
- Cold load 0x0000_0400: miss. `sram_r_en` holds until `sram_ready` (after 5 cycles) with `sram_rdata`=0x2222_2222_1111_1111 → `mem_rdata`=0x1111_1111, `cache_write_en` pulses once, `miss_count`=1.
- Reload 0x404 after that fill: hit, `ready`=1 with no stall, `mem_rdata`=0x2222_2222, `hit_count`=1.
- Store 0x404 with data 0xDEAD_BEEF → one-cycle `cache_invalid`, `sram_w_en` until `sram_ready`. The next load of 0x404 misses.
- `mem_r_en`=`mem_w_en`=1 at 0x500 → store path taken; no `sram_r_en` and no counter change.
- `rst` pulsed low during MISS → state IDLE, strobes drop immediately, `cache_write_en` never asserts, counters 0.
- Force `hit_count` to 0xFFFF, then issue a hit → it stays 0xFFFF.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry for the data-cache control stage.
package cache_pkg;

  localparam int unsigned TAG_W        = 10;
  localparam int unsigned IDX_W        = 6;
  localparam int unsigned OFF_W        = 1;
  localparam int unsigned CACHE_ADDR_W = 17;
  localparam int unsigned LINE_W       = 64;
  localparam int unsigned WORD_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MISS  = 2'd1,
    WRITE = 2'd2
  } state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  // Count enabled events; hold once every bit is set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
    end else if (i_en && (r_count != '1)) begin
      r_count <= r_count + WIDTH'(1'b1);
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/cache_controller.sv
// MEM-stage front end for a 2-way data cache: zero-wait read hits, line fill on
// read miss, write-through / no-write-allocate stores, pipeline freeze while
// an SRAM transaction is outstanding, saturating hit/miss counters.
module cache_controller
  import cache_pkg::*;
#(
  parameter int unsigned BASE_ADDR = 32'd1024,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  // MEM stage
  input  logic [31:0]             mem_addr,
  input  logic [31:0]             mem_wdata,
  input  logic                    mem_r_en,
  input  logic                    mem_w_en,
  output logic [31:0]             mem_rdata,
  output logic                    ready,
  // Cache
  output logic [CACHE_ADDR_W-1:0] cache_address,
  output logic [LINE_W-1:0]       cache_write_data,
  output logic                    cache_read_en,
  output logic                    cache_write_en,
  output logic                    cache_invalid,
  input  logic                    cache_hit,
  input  logic [WORD_W-1:0]       cache_read_data,
  // SRAM controller
  output logic [31:0]             sram_addr,
  output logic [31:0]             sram_wdata,
  output logic                    sram_r_en,
  output logic                    sram_w_en,
  input  logic [LINE_W-1:0]       sram_rdata,
  input  logic                    sram_ready,
  // Statistics
  output logic [CNT_W-1:0]        hit_count,
  output logic [CNT_W-1:0]        miss_count
);

  state_e      r_state, w_next_state;
  logic [31:0] r_req_addr, r_req_wdata;
  logic [31:0] w_addr, w_wdata;
  logic [18:0] w_off;
  logic        w_unused_off;
  logic        w_accept;
  logic        w_hit_inc, w_miss_inc;

  // In IDLE the live request drives the address path; otherwise the latched one.
  assign w_addr  = (r_state == IDLE) ? mem_addr  : r_req_addr;
  assign w_wdata = (r_state == IDLE) ? mem_wdata : r_req_wdata;

  // Only bits 18:0 of the 32-bit difference reach the cache address.
  assign w_off         = w_addr[18:0] - BASE_ADDR[18:0];
  assign w_unused_off  = ^w_off[1:0];
  assign cache_address = w_off[18:2];

  assign sram_addr        = w_addr;
  assign sram_wdata       = w_wdata;
  assign cache_write_data = sram_rdata;

  assign w_accept = (r_state == IDLE) && (mem_r_en || mem_w_en);

  // State register and request latch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_req_addr  <= mem_addr;
        r_req_wdata <= mem_wdata;
      end
    end
  end

  // Next state, strobes, load data and counter enables.
  always_comb begin
    w_next_state   = r_state;
    ready          = 1'b1;
    mem_rdata      = '0;
    cache_read_en  = 1'b0;
    cache_write_en = 1'b0;
    cache_invalid  = 1'b0;
    sram_r_en      = 1'b0;
    sram_w_en      = 1'b0;
    w_hit_inc      = 1'b0;
    w_miss_inc     = 1'b0;

    unique case (r_state)
      IDLE: begin
        // A simultaneous load+store is treated as a store.
        if (mem_w_en) begin
          cache_invalid = 1'b1;
          sram_w_en     = 1'b1;
          ready         = 1'b0;
          w_next_state  = WRITE;
        end else if (mem_r_en) begin
          cache_read_en = 1'b1;
          if (cache_hit) begin
            mem_rdata = cache_read_data;
            w_hit_inc = 1'b1;
          end else begin
            ready        = 1'b0;
            sram_r_en    = 1'b1;
            w_miss_inc   = 1'b1;
            w_next_state = MISS;
          end
        end
      end
      MISS: begin
        sram_r_en     = 1'b1;
        cache_read_en = 1'b1;
        ready         = 1'b0;
        if (sram_ready) begin
          cache_write_en = 1'b1;
          mem_rdata      = w_off[2] ? sram_rdata[63:32] : sram_rdata[31:0];
          ready          = 1'b1;
          w_next_state   = IDLE;
        end
      end
      WRITE: begin
        sram_w_en = 1'b1;
        ready     = 1'b0;
        if (sram_ready) begin
          ready        = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase

    // Reset blanks every output immediately, including mid-transaction.
    if (!rst) begin
      w_next_state   = IDLE;
      ready          = 1'b0;
      mem_rdata      = '0;
      cache_read_en  = 1'b0;
      cache_write_en = 1'b0;
      cache_invalid  = 1'b0;
      sram_r_en      = 1'b0;
      sram_w_en      = 1'b0;
      w_hit_inc      = 1'b0;
      w_miss_inc     = 1'b0;
    end
  end

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_hit_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_hit_inc),
    .o_count (hit_count)
  );

  sat_counter #(
    .WIDTH (CNT_W)
  ) u_miss_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_miss_inc),
    .o_count (miss_count)
  );

endmodule
